// File: rtl/click_line_encoder_if.sv
// Command-in / byte-out bundle for click_line_encoder.
// master = encoder side, slave = command source plus byte sink.
interface click_line_encoder_if #(
  parameter int unsigned CLICK_BITS = 10
);
  logic                  click_valid;
  logic                  click_ready;
  logic                  click_right_left;
  logic [CLICK_BITS-1:0] click_count;
  logic                  eos_valid;
  logic                  outbound_valid;
  logic                  outbound_ready;
  logic [7:0]            outbound_byte;
  logic                  end_of_file;

  modport master (
    input  click_valid, click_right_left, click_count, eos_valid, outbound_ready,
    output click_ready, outbound_valid, outbound_byte, end_of_file
  );

  modport slave (
    output click_valid, click_right_left, click_count, eos_valid, outbound_ready,
    input  click_ready, outbound_valid, outbound_byte, end_of_file
  );
endinterface

// File: rtl/click_line_encoder.sv
// click_line_encoder: turns one (direction, count) command into an ASCII line
// "R68\n" / "L0\n", using a sequential double-dabble, and can close the stream
// with a single EOF marker byte. All outputs are driven from registers.
module click_line_encoder #(
  parameter int unsigned CLICK_BITS = 10,
  parameter int unsigned DIGITS     = 4,
  parameter logic [7:0]  EOF_BYTE   = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  click_line_encoder_if.master   enc_if
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(CLICK_BITS + 1);
  localparam int unsigned PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_EMIT_DIR, S_EMIT_DIG, S_EMIT_LF, S_EMIT_EOF, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [CLICK_BITS-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            out_byte_q, out_byte_d;
  logic                  eof_q, eof_d;
  logic                  click_ready_q, click_ready_d;

  logic                  out_hs_c;
  logic                  click_hs_c;
  logic [BCD_W-1:0]      bcd_adj_c;
  logic [BCD_W+CLICK_BITS-1:0] dabble_c;
  logic [PTR_W-1:0]      msnz_c;
  logic [PTR_W-1:0]      ptr_dec_c;

  function automatic logic [7:0] digit_char(input logic [3:0] nib);
    return ASCII_0 + {4'h0, nib};
  endfunction

  assign out_hs_c   = out_valid_q && enc_if.outbound_ready;
  assign click_hs_c = enc_if.click_valid && click_ready_q;
  assign ptr_dec_c  = ptr_q - PTR_W'(1);

  // One double-dabble step: add-3 correction, then shift count MSB into BCD.
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    dabble_c = {bcd_adj_c, shift_q} << 1;
  end

  // Index of the most significant non-zero BCD nibble (0 when the value is 0).
  always_comb begin
    msnz_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msnz_c = PTR_W'(i);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    eof_d       = eof_q;

    case (state_q)
      S_IDLE: begin
        if (click_hs_c) begin
          dir_d   = enc_if.click_right_left;
          shift_d = enc_if.click_count;
          bcd_d   = '0;
          cnt_d   = CNT_W'(CLICK_BITS);
          state_d = S_CONVERT;
        end else if (enc_if.eos_valid) begin
          out_valid_d = 1'b1;
          out_byte_d  = EOF_BYTE;
          state_d     = S_EMIT_EOF;
        end
      end
      S_CONVERT: begin
        bcd_d   = dabble_c[BCD_W+CLICK_BITS-1:CLICK_BITS];
        shift_d = dabble_c[CLICK_BITS-1:0];
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_valid_d = 1'b1;
          out_byte_d  = dir_q ? ASCII_R : ASCII_L;
          state_d     = S_EMIT_DIR;
        end
      end
      S_EMIT_DIR: begin
        if (out_hs_c) begin
          ptr_d      = msnz_c;
          out_byte_d = digit_char(bcd_q[32'(msnz_c)*4 +: 4]);
          state_d    = S_EMIT_DIG;
        end
      end
      S_EMIT_DIG: begin
        if (out_hs_c) begin
          if (ptr_q == '0) begin
            out_byte_d = ASCII_LF;
            state_d    = S_EMIT_LF;
          end else begin
            ptr_d      = ptr_dec_c;
            out_byte_d = digit_char(bcd_q[32'(ptr_dec_c)*4 +: 4]);
          end
        end
      end
      S_EMIT_LF: begin
        if (out_hs_c) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_EMIT_EOF: begin
        if (out_hs_c) begin
          out_valid_d = 1'b0;
          eof_d       = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    click_ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      dir_q         <= 1'b0;
      shift_q       <= '0;
      bcd_q         <= '0;
      cnt_q         <= '0;
      ptr_q         <= '0;
      out_valid_q   <= 1'b0;
      out_byte_q    <= 8'h00;
      eof_q         <= 1'b0;
      click_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      shift_q       <= shift_d;
      bcd_q         <= bcd_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      out_valid_q   <= out_valid_d;
      out_byte_q    <= out_byte_d;
      eof_q         <= eof_d;
      click_ready_q <= click_ready_d;
    end
  end

  assign enc_if.click_ready    = click_ready_q;
  assign enc_if.outbound_valid = out_valid_q;
  assign enc_if.outbound_byte  = out_byte_q;
  assign enc_if.end_of_file    = eof_q;

endmodule
